// File: rtl/regfile_sb.sv
// Integer register file with two bypassed read ports, one write port, a debug port,
// and per-register outstanding-write counters used by decode for RAW hazard detection.
module regfile_sb #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  Wrclk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Ra,
    input  logic [ADDR_WIDTH-1:0] Rb,
    output logic [DATA_WIDTH-1:0] busA,
    output logic [DATA_WIDTH-1:0] busB,
    output logic                  rdyA,
    output logic                  rdyB,
    input  logic [ADDR_WIDTH-1:0] Rw,
    input  logic [DATA_WIDTH-1:0] busW,
    input  logic                  RegWr,
    input  logic                  iss_en,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_full,
    output logic                  err,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] rf_q  [Depth];
    logic [CNT_WIDTH-1:0]  cnt_q [Depth];
    logic                  err_q;
    logic                  iss_dec;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Read ports: writeback data forwarded ahead of the array update.
    always_comb begin
        busA = rf_q[Ra];
        if (RegWr && (Rw == Ra)) begin
            busA = busW;
        end
        if (is_zero(Ra)) begin
            busA = '0;
        end
    end

    always_comb begin
        busB = rf_q[Rb];
        if (RegWr && (Rw == Rb)) begin
            busB = busW;
        end
        if (is_zero(Rb)) begin
            busB = '0;
        end
    end

    // An operand is ready if nothing is pending, or the last pending write lands now.
    assign rdyA = (cnt_q[Ra] == '0) || (RegWr && (Rw == Ra) && (cnt_q[Ra] == CntOne));
    assign rdyB = (cnt_q[Rb] == '0) || (RegWr && (Rw == Rb) && (cnt_q[Rb] == CntOne));

    assign dbg_data = rf_q[dbg_addr];

    // A writeback retiring on the issue target this cycle frees one slot.
    assign iss_dec  = RegWr && (Rw == iss_rd) && (cnt_q[iss_rd] != '0);
    assign iss_full = (cnt_q[iss_rd] == CntMax) && !iss_dec;

    for (genvar r = 0; r < Depth; r++) begin : g_reg
        if ((ZERO_REG != 0) && (r == 0)) begin : g_hardwired
            assign rf_q[r]  = '0;
            assign cnt_q[r] = '0;
        end else begin : g_live
            logic                  hit_wr;
            logic                  inc;
            logic                  dec;
            logic [DATA_WIDTH-1:0] data_q;
            logic [CNT_WIDTH-1:0]  count_q;
            logic [CNT_WIDTH-1:0]  count_d;

            assign hit_wr = RegWr && (Rw == ADDR_WIDTH'(r));
            assign inc    = iss_en && (iss_rd == ADDR_WIDTH'(r)) && !iss_full;
            assign dec    = hit_wr && (count_q != '0);

            always_comb begin
                count_d = count_q;
                case ({inc, dec})
                    2'b10:   count_d = count_q + CntOne;
                    2'b01:   count_d = count_q - CntOne;
                    default: count_d = count_q;
                endcase
            end

            always_ff @(posedge Wrclk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    count_q <= '0;
                end else begin
                    if (hit_wr) begin
                        data_q <= busW;
                    end
                    count_q <= count_d;
                end
            end

            assign rf_q[r]  = data_q;
            assign cnt_q[r] = count_q;
        end
    end

    always_ff @(posedge Wrclk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (iss_en && iss_full) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios then randomized traffic, checked
// against an array/counter reference model.
module tb_regfile_sb;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = 2;
    localparam int ZR    = 1;
    localparam int DEPTH = 1 << AW;
    localparam int MAXC  = (1 << CW) - 1;

    logic          Wrclk = 1'b0;
    logic          rst   = 1'b1;
    logic [AW-1:0] Ra = '0, Rb = '0, Rw = '0, iss_rd = '0, dbg_addr = '0;
    logic [DW-1:0] busW = '0;
    logic          RegWr = 1'b0, iss_en = 1'b0;
    logic [DW-1:0] busA, busB, dbg_data;
    logic          rdyA, rdyB, iss_full, err;

    regfile_sb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .ZERO_REG  (ZR)
    ) dut (
        .Wrclk   (Wrclk),
        .rst     (rst),
        .Ra      (Ra),
        .Rb      (Rb),
        .busA    (busA),
        .busB    (busB),
        .rdyA    (rdyA),
        .rdyB    (rdyB),
        .Rw      (Rw),
        .busW    (busW),
        .RegWr   (RegWr),
        .iss_en  (iss_en),
        .iss_rd  (iss_rd),
        .iss_full(iss_full),
        .err     (err),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 Wrclk = ~Wrclk;

    typedef struct {
        string         tag;
        logic [DW-1:0] bus_a;
        logic [DW-1:0] bus_b;
        logic [DW-1:0] dbg;
        logic          rdy_a;
        logic          rdy_b;
        logic          full;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: architectural values and number of in-flight writes per register.
    logic [DW-1:0] m_rf  [DEPTH];
    int            m_pend[DEPTH];
    bit            m_err;

    function automatic bit m_zero(input int a);
        return (ZR != 0) && (a == 0);
    endfunction

    function automatic logic [DW-1:0] m_read(input int a);
        if (m_zero(a)) return '0;
        if (RegWr && int'(Rw) == a) return busW;
        return m_rf[a];
    endfunction

    function automatic bit m_rdy(input int a);
        return (m_pend[a] == 0) || (RegWr && int'(Rw) == a && m_pend[a] == 1);
    endfunction

    function automatic bit m_full();
        int  d   = int'(iss_rd);
        bit  frees = RegWr && (Rw == iss_rd) && (m_pend[d] > 0);
        return (m_pend[d] == MAXC) && !frees;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_rf[i]   = '0;
            m_pend[i] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step();
        int ri   = int'(iss_rd);
        int wi   = int'(Rw);
        bit full = m_full();
        bit inc  = iss_en && !full && !m_zero(ri);
        bit dec  = RegWr && (m_pend[wi] > 0);
        if (iss_en && full) m_err = 1'b1;
        if (RegWr && !m_zero(wi)) m_rf[wi] = busW;
        if (inc) m_pend[ri]++;
        if (dec) m_pend[wi]--;
    endtask

    // Drive one cycle's inputs just after the edge, queue what the outputs must show.
    task automatic drive(input bit r, input int ra, input int rb, input int rw,
                         input logic [DW-1:0] bw, input bit wr, input bit ie,
                         input int ird, input int da, input string tag);
        exp_t e;
        @(posedge Wrclk);
        #1;
        rst      = r;
        Ra       = ra[AW-1:0];
        Rb       = rb[AW-1:0];
        Rw       = rw[AW-1:0];
        busW     = bw;
        RegWr    = wr;
        iss_en   = ie;
        iss_rd   = ird[AW-1:0];
        dbg_addr = da[AW-1:0];
        if (r) model_reset();
        e.tag   = tag;
        e.bus_a = m_read(ra);
        e.bus_b = m_read(rb);
        e.dbg   = m_rf[da];
        e.rdy_a = m_rdy(ra);
        e.rdy_b = m_rdy(rb);
        e.full  = m_full();
        e.err   = m_err;
        exp_q.push_back(e);
        if (!r) model_step();
    endtask

    task automatic chk(input string tag, input string what,
                       input logic [DW-1:0] act, input logic [DW-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s.%s: got %h, expected %h", tag, what, act, want);
        end
    endtask

    always @(negedge Wrclk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "busA", busA, e.bus_a);
            chk(e.tag, "busB", busB, e.bus_b);
            chk(e.tag, "dbg_data", dbg_data, e.dbg);
            chk(e.tag, "rdyA", DW'(rdyA), DW'(e.rdy_a));
            chk(e.tag, "rdyB", DW'(rdyB), DW'(e.rdy_b));
            chk(e.tag, "iss_full", DW'(iss_full), DW'(e.full));
            chk(e.tag, "err", DW'(err), DW'(e.err));
        end
    end

    function automatic int pick();
        if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, DEPTH - 1));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        model_reset();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, a, DEPTH - 1 - a, 0, '0, 0, 0, a, a, "reset_read");
        end

        drive(0, 3, 0, 3, 32'hDEADBEEF, 1, 0, 0, 3, "bypass");
        drive(0, 3, 3, 0, '0, 0, 0, 0, 3, "after_write");

        drive(0, 0, 0, 0, 32'h1234, 1, 1, 0, 0, "zero_reg");
        drive(0, 0, 0, 0, '0, 0, 0, 0, 0, "zero_after");

        drive(0, 7, 0, 0, '0, 0, 1, 7, 7, "waw_iss1");
        drive(0, 7, 0, 0, '0, 0, 1, 7, 7, "waw_iss2");
        drive(0, 7, 0, 7, 32'h1111_1111, 1, 0, 0, 7, "waw_wb1");
        drive(0, 7, 7, 0, '0, 0, 0, 0, 7, "waw_mid");
        drive(0, 7, 7, 7, 32'h2222_2222, 1, 0, 0, 7, "waw_wb2");
        drive(0, 7, 7, 0, '0, 0, 0, 0, 7, "waw_done");

        for (int i = 0; i < 3; i++) drive(0, 9, 0, 0, '0, 0, 1, 9, 9, "fill9");
        drive(0, 9, 0, 0, '0, 0, 0, 9, 9, "full_chk");
        drive(0, 9, 0, 0, '0, 0, 1, 9, 9, "full_over");
        drive(0, 9, 0, 0, '0, 0, 0, 9, 9, "err_set");
        drive(0, 9, 9, 9, 32'hABCD, 1, 1, 9, 9, "full_wb_iss");
        drive(0, 9, 9, 0, '0, 0, 0, 9, 9, "full_again");

        drive(0, 12, 12, 12, 32'h0C0C_0C0C, 1, 0, 0, 12, "unscored_wb");
        drive(0, 12, 12, 0, '0, 0, 0, 12, 12, "unscored_after");

        drive(0, 20, 0, 0, '0, 0, 1, 20, 20, "same_iss");
        drive(0, 20, 20, 20, 32'h5A5A_5A5A, 1, 1, 20, 20, "same_all");
        drive(0, 20, 20, 0, '0, 0, 0, 20, 20, "same_after");

        drive(0, 5, 0, 0, '0, 0, 1, 5, 5, "pend5_a");
        drive(0, 5, 0, 0, '0, 0, 1, 5, 5, "pend5_b");
        drive(0, 5, 9, 0, '0, 0, 0, 5, 5, "pend5_busy");
        drive(1, 5, 9, 0, '0, 0, 0, 5, 3, "mid_reset");
        drive(0, 5, 3, 0, '0, 0, 0, 5, 3, "post_reset");

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 199) == 0, pick(), pick(), pick(), $urandom(),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, pick(), pick(),
                  "random");
        end

        @(posedge Wrclk);
        @(negedge Wrclk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
